// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Decode-to-execute pipeline register for an RV32I core. The decode half
// turns the fetched instruction into a 4-bit ALU operation code, selects the
// second ALU operand (register or immediate) and works out the write-back,
// branch and illegal-instruction flags. The execute half registers all of it
// so the ALU sees stable operands for a full cycle.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   ValidD           decode stage holds a real instruction
//   InstrD, PCD      instruction word and its address
//   RD1D, RD2D       register-file read data for rs1 / rs2
//   StallE, FlushE   hazard-unit control (flush beats stall)
//   ValidE           execute stage holds a real instruction
//   SrcAE, SrcBE     ALU operands
//   ALUControlE      ALU operation code
//   PCE, RdE         registered PC and destination register index
//   RegWriteE        write-back enable
//   BranchE          conditional branch, BranchFunct3E carries its funct3
//   IllegalE         unsupported opcode or funct field seen
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ValidD,
    input  logic [DATA_WIDTH-1:0]     InstrD,
    input  logic [DATA_WIDTH-1:0]     PCD,
    input  logic [DATA_WIDTH-1:0]     RD1D,
    input  logic [DATA_WIDTH-1:0]     RD2D,
    input  logic                      StallE,
    input  logic                      FlushE,
    output logic                      ValidE,
    output logic [DATA_WIDTH-1:0]     SrcAE,
    output logic [DATA_WIDTH-1:0]     SrcBE,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControlE,
    output logic [DATA_WIDTH-1:0]     PCE,
    output logic [REG_ADDR_WIDTH-1:0] RdE,
    output logic                      RegWriteE,
    output logic                      BranchE,
    output logic [2:0]                BranchFunct3E,
    output logic                      IllegalE
);

    // ALU operation codes understood by the execute stage
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD    = 4'b0000;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB    = 4'b0001;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLL    = 4'b0010;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT    = 4'b0011;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLTU   = 4'b0100;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR    = 4'b0101;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRL    = 4'b0110;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRA    = 4'b0111;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR     = 4'b1000;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND    = 4'b1001;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_LUIPC  = 4'b1010;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_LUI    = 4'b1011;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_PCPLUS = 4'b1100;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // Instruction fields
    logic [6:0]                w_opcode;
    logic [2:0]                w_funct3;
    logic [6:0]                w_funct7;
    logic [REG_ADDR_WIDTH-1:0] w_rd;

    // Immediates, already extended to operand width
    logic [DATA_WIDTH-1:0] w_immI;
    logic [DATA_WIDTH-1:0] w_immS;
    logic [DATA_WIDTH-1:0] w_immU;
    logic [DATA_WIDTH-1:0] w_immJ;
    logic [DATA_WIDTH-1:0] w_shamt;

    // Decoded controls before registering
    logic [ALU_CTRL_WIDTH-1:0] w_aluCtrl;
    logic [DATA_WIDTH-1:0]     w_srcB;
    logic                      w_regWrite;
    logic                      w_branch;
    logic [2:0]                w_branchFunct3;
    logic                      w_illegal;

    assign w_opcode = InstrD[6:0];
    assign w_funct3 = InstrD[14:12];
    assign w_funct7 = InstrD[31:25];
    assign w_rd     = InstrD[11:7];

    assign w_immI  = {{(DATA_WIDTH-12){InstrD[31]}}, InstrD[31:20]};
    assign w_immS  = {{(DATA_WIDTH-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
    // The U immediate is handed over unshifted; the ALU applies the <<12
    assign w_immU  = {{(DATA_WIDTH-20){1'b0}}, InstrD[31:12]};
    assign w_immJ  = {{(DATA_WIDTH-20){InstrD[31]}}, InstrD[19:12], InstrD[20],
                      InstrD[30:21], 1'b0};
    assign w_shamt = {{(DATA_WIDTH-5){1'b0}}, InstrD[24:20]};

    // Register/immediate arithmetic share one funct3 table; the alternate
    // bit picks sub over add and sra over srl.
    function automatic logic [ALU_CTRL_WIDTH-1:0] aluFromFunct3(
        input logic [2:0] f3,
        input logic       alt
    );
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Decode: operation code, operand B selection and control flags.
    // Illegal encodings are detected per opcode and scrubbed at the end so
    // they never write back or branch.
    always_comb begin
        w_aluCtrl      = ALU_ADD;
        w_srcB         = RD2D;
        w_regWrite     = 1'b0;
        w_branch       = 1'b0;
        w_branchFunct3 = 3'b000;
        w_illegal      = 1'b0;

        case (w_opcode)
            OPC_OP: begin
                w_regWrite = 1'b1;
                w_srcB     = RD2D;
                if (w_funct3 == 3'b000 || w_funct3 == 3'b101) begin
                    // Only add/sub and srl/sra have a legal alternate form
                    if (w_funct7 == FUNCT7_BASE) begin
                        w_aluCtrl = aluFromFunct3(w_funct3, 1'b0);
                    end else if (w_funct7 == FUNCT7_ALT) begin
                        w_aluCtrl = aluFromFunct3(w_funct3, 1'b1);
                    end else begin
                        w_illegal = 1'b1;
                    end
                end else if (w_funct7 == FUNCT7_BASE) begin
                    w_aluCtrl = aluFromFunct3(w_funct3, 1'b0);
                end else begin
                    w_illegal = 1'b1;
                end
            end

            OPC_OPIMM: begin
                w_regWrite = 1'b1;
                w_srcB     = w_immI;
                case (w_funct3)
                    3'b001: begin
                        w_srcB = w_shamt;
                        if (w_funct7 == FUNCT7_BASE) begin
                            w_aluCtrl = ALU_SLL;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    3'b101: begin
                        w_srcB = w_shamt;
                        if (w_funct7 == FUNCT7_BASE) begin
                            w_aluCtrl = ALU_SRL;
                        end else if (w_funct7 == FUNCT7_ALT) begin
                            w_aluCtrl = ALU_SRA;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    // Immediate forms have no subtract, so 000 is always addi
                    default: w_aluCtrl = aluFromFunct3(w_funct3, 1'b0);
                endcase
            end

            OPC_LOAD: begin
                w_regWrite = 1'b1;
                w_srcB     = w_immI;
                w_aluCtrl  = ALU_ADD;
                if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111) begin
                    w_illegal = 1'b1;
                end
            end

            OPC_STORE: begin
                w_srcB    = w_immS;
                w_aluCtrl = ALU_ADD;
                if (w_funct3[2] || w_funct3 == 3'b011) begin
                    w_illegal = 1'b1;
                end
            end

            OPC_BRANCH: begin
                w_branch       = 1'b1;
                w_branchFunct3 = w_funct3;
                w_srcB         = RD2D;
                case (w_funct3)
                    // beq/bne decide from the Zero flag of a subtract
                    3'b000, 3'b001: w_aluCtrl = ALU_SUB;
                    3'b100, 3'b101: w_aluCtrl = ALU_SLT;
                    3'b110, 3'b111: w_aluCtrl = ALU_SLTU;
                    default:        w_illegal = 1'b1;
                endcase
            end

            OPC_LUI: begin
                w_regWrite = 1'b1;
                w_srcB     = w_immU;
                w_aluCtrl  = ALU_LUI;
            end

            OPC_AUIPC: begin
                w_regWrite = 1'b1;
                w_srcB     = w_immU;
                w_aluCtrl  = ALU_LUIPC;
            end

            OPC_JAL: begin
                w_regWrite = 1'b1;
                w_srcB     = w_immJ;
                w_aluCtrl  = ALU_PCPLUS;
            end

            OPC_JALR: begin
                w_regWrite = 1'b1;
                w_srcB     = w_immI;
                w_aluCtrl  = ALU_PCPLUS;
                if (w_funct3 != 3'b000) begin
                    w_illegal = 1'b1;
                end
            end

            default: w_illegal = 1'b1;
        endcase

        // An illegal instruction must not disturb architectural state
        if (w_illegal) begin
            w_aluCtrl      = ALU_ADD;
            w_regWrite     = 1'b0;
            w_branch       = 1'b0;
            w_branchFunct3 = 3'b000;
        end

        // x0 is hard-wired to zero, so writes to it are dropped here
        if (w_rd == '0) begin
            w_regWrite = 1'b0;
        end
    end

    // Execute register. Reset and flush both leave an all-zero bubble, a
    // stall freezes everything, and an empty decode slot also loads a
    // bubble so no stale control leaks into execute.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ValidE        <= 1'b0;
            SrcAE         <= '0;
            SrcBE         <= '0;
            ALUControlE   <= '0;
            PCE           <= '0;
            RdE           <= '0;
            RegWriteE     <= 1'b0;
            BranchE       <= 1'b0;
            BranchFunct3E <= 3'b000;
            IllegalE      <= 1'b0;
        end else if (FlushE) begin
            ValidE        <= 1'b0;
            SrcAE         <= '0;
            SrcBE         <= '0;
            ALUControlE   <= '0;
            PCE           <= '0;
            RdE           <= '0;
            RegWriteE     <= 1'b0;
            BranchE       <= 1'b0;
            BranchFunct3E <= 3'b000;
            IllegalE      <= 1'b0;
        end else if (!StallE) begin
            if (ValidD) begin
                ValidE        <= 1'b1;
                SrcAE         <= RD1D;
                SrcBE         <= w_srcB;
                ALUControlE   <= w_aluCtrl;
                PCE           <= PCD;
                RdE           <= w_rd;
                RegWriteE     <= w_regWrite;
                BranchE       <= w_branch;
                BranchFunct3E <= w_branchFunct3;
                IllegalE      <= w_illegal;
            end else begin
                ValidE        <= 1'b0;
                SrcAE         <= '0;
                SrcBE         <= '0;
                ALUControlE   <= '0;
                PCE           <= '0;
                RdE           <= '0;
                RegWriteE     <= 1'b0;
                BranchE       <= 1'b0;
                BranchFunct3E <= 3'b000;
                IllegalE      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Directed bench for alu_issue_stage. Inputs change on the falling edge and
// outputs are sampled 1 time unit after the rising edge. Expected values are
// hand-decoded from the instruction encodings.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic        StallE;
    logic        FlushE;
    logic        ValidE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [3:0]  ALUControlE;
    logic [31:0] PCE;
    logic [4:0]  RdE;
    logic        RegWriteE;
    logic        BranchE;
    logic [2:0]  BranchFunct3E;
    logic        IllegalE;

    int checkCount = 0;
    int errorCount = 0;

    alu_issue_stage dut (
        .clk           (clk),
        .rst           (rst),
        .ValidD        (ValidD),
        .InstrD        (InstrD),
        .PCD           (PCD),
        .RD1D          (RD1D),
        .RD2D          (RD2D),
        .StallE        (StallE),
        .FlushE        (FlushE),
        .ValidE        (ValidE),
        .SrcAE         (SrcAE),
        .SrcBE         (SrcBE),
        .ALUControlE   (ALUControlE),
        .PCE           (PCE),
        .RdE           (RdE),
        .RegWriteE     (RegWriteE),
        .BranchE       (BranchE),
        .BranchFunct3E (BranchFunct3E),
        .IllegalE      (IllegalE)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts the check and reports a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive one decode slot on the falling edge, then step past the next
    // rising edge so the registered result can be sampled
    task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic [31:0] rd1,
                                 input logic [31:0] rd2);
        @(negedge clk);
        ValidD = valid;
        InstrD = instr;
        PCD    = pc;
        RD1D   = rd1;
        RD2D   = rd2;
        @(posedge clk);
        #1;
    endtask

    // Checks that every execute output is in its cleared state
    task automatic checkCleared(input string tag);
        checkOutput({tag, ".ValidE"},      {31'b0, ValidE},      32'h0);
        checkOutput({tag, ".SrcAE"},       SrcAE,                32'h0);
        checkOutput({tag, ".SrcBE"},       SrcBE,                32'h0);
        checkOutput({tag, ".ALUControlE"}, {28'b0, ALUControlE}, 32'h0);
        checkOutput({tag, ".PCE"},         PCE,                  32'h0);
        checkOutput({tag, ".RegWriteE"},   {31'b0, RegWriteE},   32'h0);
    endtask

    // Watchdog so the bench always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst    = 1'b1;
        ValidD = 1'b0;
        InstrD = 32'h0;
        PCD    = 32'h0;
        RD1D   = 32'h0;
        RD2D   = 32'h0;
        StallE = 1'b0;
        FlushE = 1'b0;

        // Outputs are cleared while reset is held
        repeat (2) @(posedge clk);
        #1;
        checkCleared("reset");
        @(negedge clk);
        rst = 1'b0;

        // add x3,x1,x2
        applyStimulus(1'b1, 32'h002081B3, 32'h100, 32'd5, 32'd7);
        checkOutput("add.ALUControlE", {28'b0, ALUControlE}, 32'h0);
        checkOutput("add.SrcAE",       SrcAE,                32'd5);
        checkOutput("add.SrcBE",       SrcBE,                32'd7);
        checkOutput("add.RdE",         {27'b0, RdE},         32'd3);
        checkOutput("add.RegWriteE",   {31'b0, RegWriteE},   32'd1);
        checkOutput("add.ValidE",      {31'b0, ValidE},      32'd1);
        checkOutput("add.PCE",         PCE,                  32'h100);
        checkOutput("add.IllegalE",    {31'b0, IllegalE},    32'd0);

        // sub x4,x1,x2
        applyStimulus(1'b1, 32'h40208233, 32'h104, 32'd9, 32'd2);
        checkOutput("sub.ALUControlE", {28'b0, ALUControlE}, 32'h1);
        checkOutput("sub.RdE",         {27'b0, RdE},         32'd4);

        // srai x5,x6,4: shift amount is the zero-extended rs2 field
        applyStimulus(1'b1, 32'h40435293, 32'h108, 32'h80000000, 32'h55);
        checkOutput("srai.ALUControlE", {28'b0, ALUControlE}, 32'h7);
        checkOutput("srai.SrcBE",       SrcBE,                32'd4);
        checkOutput("srai.SrcAE",       SrcAE,                32'h80000000);
        checkOutput("srai.RegWriteE",   {31'b0, RegWriteE},   32'd1);

        // addi x1,x0,-1: sign-extended I immediate
        applyStimulus(1'b1, 32'hFFF00093, 32'h10C, 32'h0, 32'h1234);
        checkOutput("addi.ALUControlE", {28'b0, ALUControlE}, 32'h0);
        checkOutput("addi.SrcBE",       SrcBE,                32'hFFFFFFFF);

        // lui x1,0x12345: immediate passed unshifted
        applyStimulus(1'b1, 32'h123450B7, 32'h110, 32'h0, 32'h0);
        checkOutput("lui.ALUControlE", {28'b0, ALUControlE}, 32'hB);
        checkOutput("lui.SrcBE",       SrcBE,                32'h00012345);
        checkOutput("lui.RegWriteE",   {31'b0, RegWriteE},   32'd1);

        // auipc x5,0xABCDE
        applyStimulus(1'b1, 32'hABCDE297, 32'h114, 32'h0, 32'h0);
        checkOutput("auipc.ALUControlE", {28'b0, ALUControlE}, 32'hA);
        checkOutput("auipc.SrcBE",       SrcBE,                32'h000ABCDE);

        // sw x2,-4(x1): split S immediate, no write-back
        applyStimulus(1'b1, 32'hFE20AE23, 32'h118, 32'h200, 32'h77);
        checkOutput("sw.ALUControlE", {28'b0, ALUControlE}, 32'h0);
        checkOutput("sw.SrcBE",       SrcBE,                32'hFFFFFFFC);
        checkOutput("sw.RegWriteE",   {31'b0, RegWriteE},   32'd0);

        // bltu x1,x2,0
        applyStimulus(1'b1, 32'h0020E063, 32'h11C, 32'd3, 32'd8);
        checkOutput("bltu.ALUControlE",   {28'b0, ALUControlE},   32'h4);
        checkOutput("bltu.BranchE",       {31'b0, BranchE},       32'd1);
        checkOutput("bltu.BranchFunct3E", {29'b0, BranchFunct3E}, 32'd6);
        checkOutput("bltu.RegWriteE",     {31'b0, RegWriteE},     32'd0);
        checkOutput("bltu.SrcBE",         SrcBE,                  32'd8);

        // Branch funct3 010 is not a branch
        applyStimulus(1'b1, 32'h0020A063, 32'h120, 32'd3, 32'd8);
        checkOutput("br010.IllegalE", {31'b0, IllegalE}, 32'd1);
        checkOutput("br010.BranchE",  {31'b0, BranchE},  32'd0);

        // OP funct3 001 with funct7 0100000 is illegal
        applyStimulus(1'b1, 32'h40209233, 32'h124, 32'd3, 32'd8);
        checkOutput("sllalt.IllegalE",  {31'b0, IllegalE},  32'd1);
        checkOutput("sllalt.RegWriteE", {31'b0, RegWriteE}, 32'd0);

        // Opcode 0x7F with rd = x3
        applyStimulus(1'b1, 32'h000001FF, 32'h128, 32'd1, 32'd2);
        checkOutput("op7f.IllegalE",    {31'b0, IllegalE},    32'd1);
        checkOutput("op7f.RegWriteE",   {31'b0, RegWriteE},   32'd0);
        checkOutput("op7f.ALUControlE", {28'b0, ALUControlE}, 32'h0);
        checkOutput("op7f.ValidE",      {31'b0, ValidE},      32'd1);

        // add x0,x1,x2: write to x0 is dropped
        applyStimulus(1'b1, 32'h00208033, 32'h12C, 32'd1, 32'd2);
        checkOutput("addx0.RegWriteE", {31'b0, RegWriteE}, 32'd0);
        checkOutput("addx0.IllegalE",  {31'b0, IllegalE},  32'd0);

        // jal x1,0
        applyStimulus(1'b1, 32'h000000EF, 32'h140, 32'h0, 32'h0);
        checkOutput("jal.ALUControlE", {28'b0, ALUControlE}, 32'hC);
        checkOutput("jal.RegWriteE",   {31'b0, RegWriteE},   32'd1);

        // Stall three cycles while decode inputs keep changing
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h002081B3 + (i << 7), 32'h200 + i, 32'd50 + i, 32'd60);
            checkOutput("stall.ALUControlE", {28'b0, ALUControlE}, 32'hC);
            checkOutput("stall.PCE",         PCE,                  32'h140);
            checkOutput("stall.RdE",         {27'b0, RdE},         32'd1);
            checkOutput("stall.ValidE",      {31'b0, ValidE},      32'd1);
        end

        // Flush with stall: flush wins
        FlushE = 1'b1;
        applyStimulus(1'b1, 32'h002081B3, 32'h300, 32'd5, 32'd7);
        checkCleared("flush");
        FlushE = 1'b0;
        StallE = 1'b0;

        // Bubble from decode
        applyStimulus(1'b1, 32'h002081B3, 32'h304, 32'd5, 32'd7);
        checkOutput("pre-bubble.ValidE", {31'b0, ValidE}, 32'd1);
        applyStimulus(1'b0, 32'h002081B3, 32'h308, 32'd5, 32'd7);
        checkOutput("bubble.ValidE",    {31'b0, ValidE},    32'd0);
        checkOutput("bubble.RegWriteE", {31'b0, RegWriteE}, 32'd0);

        // Reset mid-stream while decode keeps holding add
        applyStimulus(1'b1, 32'h002081B3, 32'h400, 32'd5, 32'd7);
        checkOutput("pre-reset.ValidE", {31'b0, ValidE}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkCleared("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post-reset.ValidE",      {31'b0, ValidE},      32'd1);
        checkOutput("post-reset.SrcAE",       SrcAE,                32'd5);
        checkOutput("post-reset.PCE",         PCE,                  32'h400);
        checkOutput("post-reset.RegWriteE",   {31'b0, RegWriteE},   32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-to-execute pipeline stage that drives the ALU operand and control interface. It takes a fetched RV32I instruction, its PC and the two register-file read values. It decodes the 4-bit ALU operation code and selects the immediate or register operands, then registers the result into the execute stage. Pipeline control is a hold/flush handshake from the hazard unit.

## Interface
- DATA_WIDTH, 32, operand/PC/instruction width
- ALU_CTRL_WIDTH, 4, ALU operation code width
- REG_ADDR_WIDTH, 5, register index width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ValidD  in  1  decode-stage instruction present
- InstrD  in  DATA_WIDTH  instruction word
- PCD  in  DATA_WIDTH  instruction address
- RD1D, RD2D  in  DATA_WIDTH  register-file read data for rs1, rs2
- StallE  in  1  hold execute register contents
- FlushE  in  1  insert bubble into execute
- ValidE  out  1  execute-stage instruction present
- SrcAE, SrcBE  out  DATA_WIDTH  ALU operands
- ALUControlE  out  ALU_CTRL_WIDTH  ALU operation code
- PCE  out  DATA_WIDTH  registered PC
- RdE  out  REG_ADDR_WIDTH  destination register
- RegWriteE  out  1  write-back enable
- BranchE  out  1  conditional branch; BranchFunct3E (3 bits) carries funct3
- IllegalE  out  1  unsupported opcode/funct seen

## Operation
- ALU codes:
  - 0000 add
  - 0001 sub
  - 0010 sll
  - 0011 slt
  - 0100 sltu
  - 0101 xor
  - 0110 srl
  - 0111 sra
  - 1000 or
  - 1001 and
  - 1010 lui+PC
  - 1011 lui
  - 1100 PC+4
- OP (0110011), funct3/funct7[5]:
  - 000/0 → 0000; 000/1 → 0001
  - 001 → 0010; 010 → 0011; 011 → 0100; 100 → 0101
  - 101/0 → 0110; 101/1 → 0111
  - 110 → 1000; 111 → 1001
  - SrcB = RD2D.
- OP-IMM (0010011): same map except funct3 000 is always add. SrcB = sign-extended Instr[31:20]. For shifts, SrcB = zero-extended Instr[24:20]. funct7[5] selects srai.
- LOAD (0000011): add; SrcB = I-immediate.
- STORE (0100011): add; SrcB = sign-extended {Instr[31:25], Instr[11:7]}.
- BRANCH (1100011): SrcB = RD2D, BranchE = 1.
  - funct3 000/001 → 0001 (decision from Zero).
  - 100/101 → 0011.
  - 110/111 → 0100.
  - 010/011 → illegal.
- LUI (0110111) → 1011; AUIPC (0010111) → 1010. SrcB = zero-extended Instr[31:12], unshifted; the ALU applies <<12.
- JAL (1101111), JALR (1100111) → 1100.
- SrcA = RD1D for all encodings.
- RegWriteE = 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR. It is forced to 0 when rd = 0, when ValidD = 0, and when the instruction is illegal.
- Illegal instruction (any other opcode, or bad funct): IllegalE = 1, ALUControl = 0000, RegWrite = 0, Branch = 0.
- A bubble (ValidD = 0) loads ValidE = 0 and all control outputs 0.

## Timing
- One-cycle latency: decode inputs at edge N appear on the E outputs after edge N.
- Reset (async, immediate): all outputs 0, including ValidE, ALUControlE = 0000, and the operands. Asserting rst mid-operation clears the instruction in flight. Deassertion takes effect at the next edge.
- Priority at each edge: rst > FlushE > StallE > load.
- FlushE = 1: ValidE, RegWriteE, BranchE, IllegalE and ALUControlE are cleared; datapath outputs are cleared to 0.
- FlushE and StallE together: flush wins.
- StallE = 1 (no flush): all E outputs hold their values for any number of cycles. Decode inputs are ignored.
- No combinational path from D inputs to E outputs.

## Test plan
- Reset: assert rst mid-stream while holding add → all outputs 0 immediately. Release → the next edge loads the instruction.
- add x3,x1,x2 (0x002081B3) with RD1=5, RD2=7, PCD=0x100 → next cycle:
  - ALUControlE = 0000, SrcA = 5, SrcB = 7
  - RdE = 3, RegWriteE = 1, ValidE = 1
- srai x5,x6,4 (0x40435293) → ALUControlE = 0111, SrcBE = 4. addi x1,x0,-1 (0xFFF00093) → 0000, SrcBE = 0xFFFFFFFF.
- lui x1,0x12345 (0x123450B7) → 1011, SrcBE = 0x00012345. bltu (funct3 110) → 0100, BranchE = 1, RegWriteE = 0.
- StallE held 3 cycles while inputs change → E outputs unchanged. FlushE with StallE = 1 → ValidE = 0 next edge.
- Opcode 0x7F → IllegalE = 1, RegWriteE = 0, ALUControlE = 0000. add with rd = x0 → RegWriteE = 0.
